// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry / mret sequencer placed in front of the CSR file.
//
// Picks between a synchronous exception from execute and the machine
// interrupts (software, timer, external). It kills the execute instruction
// when a trap is taken, pulses the CSR file's trap inputs, and then issues a
// fetch redirect to mtvec (trap entry) or mepc (mret). The pipeline is
// flushed for every cycle of the sequence.
//
// Handshake semantics: there is no backpressure anywhere in this block.
// A request (instr_valid_i qualified exc_valid_i / irq / mret_i) is consumed
// on the clock edge of any IDLE cycle in which it is presented. trap_active_o
// and redirect_valid_o are single-cycle pulses that the consumer must take
// in that same cycle.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   instr_valid_i, pc_i    execute-stage instruction valid and its PC
//   exc_valid_i/cause_i    exception raised by the execute instruction
//   mret_i                 execute instruction is mret
//   mstatus_mie_i, mie_i   global and per-source interrupt enables
//   msip_i, mtip_i         software/timer interrupts (synchronous, level)
//   meip_i                 external interrupt (asynchronous, level)
//   mtvec_i, mepc_i        CSR file outputs used for the redirect target
//   kill_o                 combinational squash of the execute instruction
//   trap_active_o          one-cycle pulse with trap_cause_o / trap_mepc_o
//   flush_o                flush fetch/decode/execute (from state register)
//   redirect_valid_o/pc_o  one-cycle fetch redirect
//   dbg_state_o            current FSM state (0 IDLE, 1 TRAP, 2 REDIRECT, 3 RET)
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic            mret_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            meip_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            kill_o,
  output logic            trap_active_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_mepc_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      dbg_state_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_TRAP     = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [1:0] S_RET      = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [XLEN-1:0]        cause_q, cause_d;
  logic [XLEN-1:0]        mepc_q, mepc_d;
  logic                   vec_q, vec_d;
  logic [SYNC_STAGES-1:0] meip_sync_q, meip_sync_d;

  logic       meip_s;
  logic       p3, p7, p11;
  logic       irq_req;
  logic       exc_req;
  logic       mret_req;
  logic [3:0] irq_code;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] tvec_off;

  // External interrupt synchronizer: shift in at bit 0, use the oldest bit.
  always_comb begin
    meip_sync_d = {meip_sync_q[SYNC_STAGES-2:0], meip_i};
  end

  always_comb begin
    meip_s   = meip_sync_q[SYNC_STAGES-1];
    p11      = meip_s & mie_i[11];
    p3       = msip_i & mie_i[3];
    p7       = mtip_i & mie_i[7];
    irq_req  = mstatus_mie_i & (p11 | p3 | p7) & instr_valid_i;
    exc_req  = instr_valid_i & exc_valid_i;
    mret_req = instr_valid_i & mret_i;
    if (p11)     irq_code = 4'd11;
    else if (p3) irq_code = 4'd3;
    else         irq_code = 4'd7;
  end

  // State register plus the trap context latched on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cause_q     <= '0;
      mepc_q      <= '0;
      vec_q       <= 1'b0;
      meip_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      mepc_q      <= mepc_d;
      vec_q       <= vec_d;
      meip_sync_q <= meip_sync_d;
    end
  end

  // Next-state and context capture. Only IDLE accepts requests; an
  // interrupt that loses to an exception stays pending because the sources
  // are level signals.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    mepc_d  = mepc_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          cause_d      = '0;
          cause_d[3:0] = exc_cause_i;
          mepc_d       = pc_i;
          vec_d        = 1'b0;
          state_d      = S_TRAP;
        end else if (irq_req) begin
          cause_d           = '0;
          cause_d[XLEN-1]   = 1'b1;
          cause_d[3:0]      = irq_code;
          mepc_d            = pc_i;
          vec_d             = 1'b1;
          state_d           = S_TRAP;
        end else if (mret_req) begin
          state_d = S_RET;
        end
      end
      S_TRAP:     state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      S_RET:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Vectored mode only applies to interrupts and only for mtvec mode 2'b01;
  // modes 2'b10/2'b11 fall back to direct. The add wraps at XLEN bits.
  always_comb begin
    tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
    tvec_off  = {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
  end

  always_comb begin
    kill_o           = 1'b0;
    trap_active_o    = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    trap_cause_o     = cause_q;
    trap_mepc_o      = mepc_q;
    dbg_state_o      = state_q;
    case (state_q)
      S_IDLE: begin
        // mret is not killed: it commits so the CSR file restores mstatus.
        // Gated by reset so every output reads 0 while reset is held.
        kill_o = (exc_req | irq_req) & ~rst_i;
      end
      S_TRAP: begin
        trap_active_o = 1'b1;
        flush_o       = 1'b1;
      end
      S_REDIRECT: begin
        redirect_valid_o = 1'b1;
        flush_o          = 1'b1;
        if (vec_q && (mtvec_i[1:0] == 2'b01)) redirect_pc_o = tvec_base + tvec_off;
        else                                  redirect_pc_o = tvec_base;
      end
      S_RET: begin
        redirect_valid_o = 1'b1;
        flush_o          = 1'b1;
        redirect_pc_o    = mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed vectors, expected trap and redirect
// pulses queued with the cycle they must appear in; a monitor on the falling
// edge pops and compares them.
module tb_trap_ctrl;
  localparam int XLEN = 32;
  localparam int SYNC_STAGES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic            instr_valid_i = 0;
  logic [XLEN-1:0] pc_i = '0;
  logic            exc_valid_i = 0;
  logic [3:0]      exc_cause_i = '0;
  logic            mret_i = 0;
  logic            mstatus_mie_i = 0;
  logic [XLEN-1:0] mie_i = '0;
  logic            msip_i = 0, mtip_i = 0, meip_i = 0;
  logic [XLEN-1:0] mtvec_i = 32'h0000_0801;
  logic [XLEN-1:0] mepc_i = '0;
  logic            kill_o, trap_active_o, flush_o, redirect_valid_o;
  logic [XLEN-1:0] trap_cause_o, trap_mepc_o, redirect_pc_o;
  logic [1:0]      dbg_state_o;

  trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_valid_i(instr_valid_i), .pc_i(pc_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .mret_i(mret_i),
    .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .msip_i(msip_i),
    .mtip_i(mtip_i), .meip_i(meip_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .kill_o(kill_o), .trap_active_o(trap_active_o), .trap_cause_o(trap_cause_o),
    .trap_mepc_o(trap_mepc_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [95:0] exp_trap_q[$];   // {cycle, cause, mepc}
  logic [63:0] exp_redir_q[$];  // {cycle, pc}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a full trap sequence whose kill cycle is the current cycle.
  task automatic push_trap(input logic [31:0] cause, input logic [31:0] mepc,
                           input logic [31:0] rpc);
    exp_trap_q.push_back({cyc + 1, cause, mepc});
    exp_redir_q.push_back({cyc + 2, rpc});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [95:0] te;
    logic [63:0] re;
    logic        exp_tr, exp_rd;
    exp_tr = (exp_trap_q.size() != 0) && (exp_trap_q[0][95:64] == cyc);
    exp_rd = (exp_redir_q.size() != 0) && (exp_redir_q[0][63:32] == cyc);
    chk("trap_active", {31'b0, trap_active_o}, {31'b0, exp_tr});
    chk("redirect_valid", {31'b0, redirect_valid_o}, {31'b0, exp_rd});
    chk("flush", {31'b0, flush_o}, {31'b0, exp_tr | exp_rd});
    if (trap_active_o && exp_tr) begin
      te = exp_trap_q.pop_front();
      chk("trap_cause", trap_cause_o, te[63:32]);
      chk("trap_mepc", trap_mepc_o, te[31:0]);
    end
    if (redirect_valid_o && exp_rd) begin
      re = exp_redir_q.pop_front();
      chk("redirect_pc", redirect_pc_o, re[31:0]);
    end
    if (!redirect_valid_o) chk("redirect_pc_idle", redirect_pc_o, 32'h0);
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    tick();
    chk("rst_kill", {31'b0, kill_o}, 32'h0);
    chk("rst_state", {30'b0, dbg_state_o}, 32'h0);
    chk("rst_cause", trap_cause_o, 32'h0);
    chk("rst_mepc", trap_mepc_o, 32'h0);
    rst_i = 1'b0;
    tick();

    // Exception, direct target because exceptions never vector
    instr_valid_i = 1; exc_valid_i = 1; exc_cause_i = 4'd2; pc_i = 32'h100;
    #1 chk("exc_kill", {31'b0, kill_o}, 32'h1);
    push_trap(32'h0000_0002, 32'h100, 32'h800);
    tick();
    instr_valid_i = 0; exc_valid_i = 0;
    chk("exc_state_trap", {30'b0, dbg_state_o}, 32'h1);
    tick(); tick();

    // Vectored timer interrupt
    mstatus_mie_i = 1; mie_i = 32'h80; mtip_i = 1; instr_valid_i = 1; pc_i = 32'h200;
    #1 chk("tmr_kill", {31'b0, kill_o}, 32'h1);
    push_trap(32'h8000_0007, 32'h200, 32'h81C);
    tick();
    mtip_i = 0; instr_valid_i = 0;
    tick(); tick();

    // External interrupt: synchronizer latency, then priority over msip/mtip
    mie_i = 32'h888; instr_valid_i = 1; pc_i = 32'h240; meip_i = 1;
    #1 chk("meip_lat0", {31'b0, kill_o}, 32'h0);
    tick();
    chk("meip_lat1", {31'b0, kill_o}, 32'h0);
    tick();
    msip_i = 1; mtip_i = 1;
    #1 chk("meip_lat2", {31'b0, kill_o}, 32'h1);
    push_trap(32'h8000_000B, 32'h240, 32'h82C);
    tick();
    meip_i = 0; msip_i = 0; mtip_i = 0; instr_valid_i = 0;
    tick(); tick();

    // All pending but globally disabled: nothing taken
    mstatus_mie_i = 0; meip_i = 1; msip_i = 1; mtip_i = 1; instr_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mie_off_kill", {31'b0, kill_o}, 32'h0);
      tick();
    end
    meip_i = 0; msip_i = 0; mtip_i = 0; instr_valid_i = 0;
    tick(); tick();

    // mret alone
    mret_i = 1; instr_valid_i = 1; mepc_i = 32'h340;
    #1 chk("mret_kill", {31'b0, kill_o}, 32'h0);
    exp_redir_q.push_back({cyc + 1, 32'h340});
    tick();
    mret_i = 0; instr_valid_i = 0;
    tick(); tick();

    // Qualifier: exception and mret without instr_valid_i are ignored
    exc_valid_i = 1; mret_i = 1;
    #1 chk("unqual_kill", {31'b0, kill_o}, 32'h0);
    tick(); tick();
    exc_valid_i = 0; mret_i = 0;

    // Collision: exception + mret + pending timer in one cycle
    mstatus_mie_i = 1; mie_i = 32'h80; mtip_i = 1;
    instr_valid_i = 1; exc_valid_i = 1; mret_i = 1; exc_cause_i = 4'd5; pc_i = 32'h300;
    #1 chk("col_kill", {31'b0, kill_o}, 32'h1);
    push_trap(32'h0000_0005, 32'h300, 32'h800);
    tick();
    exc_valid_i = 0; mret_i = 0; pc_i = 32'h304;
    #1 chk("col_trap_kill", {31'b0, kill_o}, 32'h0);
    tick();
    chk("col_redir_kill", {31'b0, kill_o}, 32'h0);
    tick();
    chk("col_tmr_kill", {31'b0, kill_o}, 32'h1);
    push_trap(32'h8000_0007, 32'h304, 32'h81C);
    tick();
    mtip_i = 0; instr_valid_i = 0;
    tick(); tick(); tick();

    // Reset while in TRAP: outputs drop at once, no redirect afterwards
    instr_valid_i = 1; exc_valid_i = 1; exc_cause_i = 4'd4; pc_i = 32'h400;
    #1 chk("rst_seq_kill", {31'b0, kill_o}, 32'h1);
    tick();
    instr_valid_i = 0; exc_valid_i = 0;
    chk("rst_seq_in_trap", {30'b0, dbg_state_o}, 32'h1);
    rst_i = 1;
    #1;
    chk("rst_seq_trap_active", {31'b0, trap_active_o}, 32'h0);
    chk("rst_seq_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_seq_cause", trap_cause_o, 32'h0);
    chk("rst_seq_mepc", trap_mepc_o, 32'h0);
    chk("rst_seq_state", {30'b0, dbg_state_o}, 32'h0);
    tick();
    rst_i = 0;
    for (int i = 0; i < 4; i++) tick();

    chk("trap_q_empty", exp_trap_q.size(), 32'h0);
    chk("redir_q_empty", exp_redir_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap and return sequencer sitting directly upstream of the execute-stage CSR register file. Arbitrates synchronous exceptions from execute against machine interrupts (software, timer, external), and drives the CSR file's trap_active / trap_cause / trap_mepc inputs. Consumes the CSR file's mtvec / mepc outputs to generate the fetch redirect for trap entry and mret, and flushes the pipeline while sequencing.

## Interface
- XLEN, 32, data/address width (from tcore_param)
- SYNC_STAGES, 2, synchronizer depth for meip_i (≥2)

- clk_i  in  1  core clock
- rst_i  in  1  reset; **one clock; reset is asynchronous and active-high**
- instr_valid_i  in  1  valid instruction in execute this cycle
- pc_i  in  XLEN  PC of the execute instruction
- exc_valid_i  in  1  execute instruction raised an exception (qualified by instr_valid_i)
- exc_cause_i  in  4  exception code (0..15)
- mret_i  in  1  execute instruction is mret (qualified by instr_valid_i)
- mstatus_mie_i  in  1  global machine interrupt enable
- mie_i  in  XLEN  CSR mie value (bits 3, 7, 11 used)
- msip_i, mtip_i  in  1 each  software/timer interrupt, synchronous to clk_i, level
- meip_i  in  1  external interrupt, asynchronous, level
- mtvec_i  in  XLEN  CSR mtvec
- mepc_i  in  XLEN  CSR mepc
- kill_o  out  1  combinational: squash commit of the execute instruction this cycle
- trap_active_o  out  1  one-cycle pulse to CSR file
- trap_cause_o  out  XLEN  mcause value, valid with trap_active_o
- trap_mepc_o  out  XLEN  mepc value, valid with trap_active_o
- flush_o  out  1  invalidate fetch/decode/execute; registered
- redirect_valid_o  out  1  one-cycle pulse, fetch loads redirect_pc_o
- redirect_pc_o  out  XLEN  redirect target

## Operation
- FSM states: IDLE, TRAP, REDIRECT, RET.
- meip_i passes through SYNC_STAGES flops (reset 0) → meip_s. Pending vector: p11=meip_s&mie_i[11], p3=msip_i&mie_i[3], p7=mtip_i&mie_i[7]; irq_req = mstatus_mie_i & (p11|p3|p7) & instr_valid_i.
- IDLE priority, highest first: exception (instr_valid_i&exc_valid_i) > interrupt (irq_req) > mret (instr_valid_i&mret_i).
- Exception accept: kill_o=1; latch cause={1'b0, 27'b0, exc_cause_i}, mepc=pc_i, vec=0; → TRAP.
- Interrupt accept: kill_o=1; code = 11 if p11, else 3 if p3, else 7; latch cause={1'b1, 27'b0, code}, mepc=pc_i, vec=1; → TRAP.
- mret accept: kill_o=0 (mret commits; CSR file restores mstatus on that edge); → RET.
- TRAP: trap_active_o=1, trap_cause_o/trap_mepc_o = latched values, flush_o=1; → REDIRECT.
- REDIRECT: redirect_valid_o=1, flush_o=1; base={mtvec_i[31:2],2'b00}; redirect_pc_o = base + (cause[3:0]<<2) if vec & mtvec_i[1:0]==2'b01, else base; → IDLE.
- RET: redirect_valid_o=1, flush_o=1, redirect_pc_o=mepc_i; → IDLE.
- In TRAP/REDIRECT/RET all new requests ignored and kill_o=0; level interrupts remain pending and are re-evaluated in IDLE.
- mtvec[1:0] of 2'b10/2'b11 treated as direct. Vector offset computed modulo 2^XLEN (no overflow detection).
- trap_cause_o, trap_mepc_o hold last latched values outside TRAP; redirect_pc_o is 0 outside REDIRECT/RET.

## Timing
- Reset (async assert, clk-synchronous release): state IDLE; synchronizer flops, latched cause/mepc/vec = 0; all outputs 0.
- Exception/interrupt accepted at cycle N: kill_o at N (comb); trap_active_o, flush_o at N+1; redirect_valid_o, flush_o at N+2; IDLE at N+3 (next accept earliest N+3).
- mret accepted at N: redirect_valid_o, flush_o at N+1; IDLE at N+2.
- meip_i to irq_req latency: SYNC_STAGES cycles.
- Exception and mret same cycle: exception wins, mret dropped. Exception and interrupt same cycle: exception wins, interrupt stays pending.
- exc_valid_i/mret_i with instr_valid_i=0: ignored.
- Reset mid-sequence: returns to IDLE immediately; no trap_active_o or redirect pulse emitted afterward.

## Test plan
- Exception: pc_i=0x0000_0100, exc_cause_i=2, mtvec_i=0x0000_0801 → kill_o at N, trap_active_o at N+1 with cause 0x0000_0002, mepc 0x100; redirect_pc_o=0x0000_0800 at N+2.
- Vectored timer: mstatus_mie_i=1, mie_i[7]=1, mtip_i=1, pc_i=0x200, mtvec_i=0x0000_0801 → cause 0x8000_0007, mepc 0x200, redirect_pc_o=0x0000_081C.
- Priority: meip_i, msip_i, mtip_i all high, all enabled → cause 0x8000_000B after SYNC_STAGES; with mstatus_mie_i=0 → no trap, kill_o=0.
- Collision: exc_valid_i=1, mret_i=1, mtip_i pending in one cycle → exception cause taken, no RET redirect; timer trap follows at earliest N+3.
- mret: mret_i=1, mepc_i=0x0000_0340 → kill_o=0, redirect_valid_o at N+1 with 0x0000_0340, flush_o high one cycle.
- Reset in TRAP state: assert rst_i asynchronously → all outputs 0 same cycle, no redirect pulse after release.
